owr_temp_sequencer: RTL and testbench

OWR_TEMP_SEQUENCER -- requirements
Module: owr_temp_sequencer

---
 rtl/owr_temp_sequencer.sv | 154 +++++++++++++++
 tb/tb_owr_temp_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/owr_temp_sequencer.sv
// DS18B20 measurement sequencer driving a byte-level 1-wire master:
// reset/skip/convert, conversion wait, reset/skip/read-scratchpad, two reads.
module owr_temp_sequencer #(
  parameter int CONV_WAIT = 9000000,
  parameter int PERIOD    = 12000000,
  parameter int TO_CYCLES = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        m_cmd_valid,
  input  logic        m_cmd_ready,
  output logic [1:0]  m_cmd,
  output logic [7:0]  m_wdata,
  input  logic        m_done,
  input  logic [7:0]  m_rdata,
  input  logic        m_presence,
  output logic [15:0] o_temp,
  output logic        o_temp_valid,
  output logic        o_err
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_RST1  = 4'd1;
  localparam logic [3:0] S_SKIP1 = 4'd2;
  localparam logic [3:0] S_CONV  = 4'd3;
  localparam logic [3:0] S_WAITC = 4'd4;
  localparam logic [3:0] S_RST2  = 4'd5;
  localparam logic [3:0] S_SKIP2 = 4'd6;
  localparam logic [3:0] S_RDSP  = 4'd7;
  localparam logic [3:0] S_RD0   = 4'd8;
  localparam logic [3:0] S_RD1   = 4'd9;

  localparam logic        AUTO      = (PERIOD > 0);
  localparam logic [31:0] PER_LAST  = (PERIOD > 0)    ? 32'(PERIOD - 1)    : 32'd0;
  localparam logic [31:0] WAIT_LAST = (CONV_WAIT > 0) ? 32'(CONV_WAIT - 1) : 32'd0;
  localparam logic [31:0] TO_LAST   = (TO_CYCLES > 0) ? 32'(TO_CYCLES - 1) : 32'd0;

  logic [3:0]  state;
  logic [3:0]  next_state;
  logic        wait_phase;
  logic [31:0] per_cnt;
  logic [31:0] conv_cnt;
  logic [31:0] wd_cnt;
  logic [7:0]  lsb;
  logic        start_seq;
  logic        presence_fail;

  assign o_busy        = (state != S_IDLE);
  assign start_seq     = i_start || (AUTO && (per_cnt == PER_LAST));
  assign presence_fail = ((state == S_RST1) || (state == S_RST2)) && !m_presence;

  // Command fields decode from state, so they cannot move while a command waits for ready.
  always_comb begin
    m_cmd   = 2'b00;
    m_wdata = 8'h00;
    case (state)
      S_SKIP1, S_SKIP2: begin m_cmd = 2'b01; m_wdata = 8'hCC; end
      S_CONV:           begin m_cmd = 2'b01; m_wdata = 8'h44; end
      S_RDSP:           begin m_cmd = 2'b01; m_wdata = 8'hBE; end
      S_RD0, S_RD1:     m_cmd = 2'b10;
      default:          ;
    endcase
  end

  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_RST1:  next_state = S_SKIP1;
      S_SKIP1: next_state = S_CONV;
      S_CONV:  next_state = S_WAITC;
      S_RST2:  next_state = S_SKIP2;
      S_SKIP2: next_state = S_RDSP;
      S_RDSP:  next_state = S_RD0;
      S_RD0:   next_state = S_RD1;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      wait_phase   <= 1'b0;
      m_cmd_valid  <= 1'b0;
      per_cnt      <= '0;
      conv_cnt     <= '0;
      wd_cnt       <= '0;
      lsb          <= '0;
      o_temp       <= '0;
      o_temp_valid <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_temp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_seq) begin
            state       <= S_RST1;
            wait_phase  <= 1'b0;
            m_cmd_valid <= 1'b1;
            wd_cnt      <= '0;
            per_cnt     <= '0;
            o_err       <= 1'b0;
          end else if (AUTO) begin
            per_cnt <= per_cnt + 32'd1;
          end
        end
        S_WAITC: begin
          if (conv_cnt >= WAIT_LAST) begin
            state       <= S_RST2;
            wait_phase  <= 1'b0;
            m_cmd_valid <= 1'b1;
            wd_cnt      <= '0;
            conv_cnt    <= '0;
          end else begin
            conv_cnt <= conv_cnt + 32'd1;
          end
        end
        default: begin
          // A completion in the wait phase wins over a watchdog expiry in the same cycle.
          if (wait_phase && m_done) begin
            wait_phase <= 1'b0;
            wd_cnt     <= '0;
            if (presence_fail) begin
              o_err <= 1'b1;
              state <= S_IDLE;
            end else begin
              state       <= next_state;
              m_cmd_valid <= (next_state != S_WAITC) && (next_state != S_IDLE);
              if (state == S_RD0) lsb <= m_rdata;
              if (state == S_RD1) begin
                o_temp       <= {m_rdata, lsb};
                o_temp_valid <= 1'b1;
              end
            end
          end else if (wd_cnt >= TO_LAST) begin
            o_err       <= 1'b1;
            m_cmd_valid <= 1'b0;
            wait_phase  <= 1'b0;
            wd_cnt      <= '0;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
            if (!wait_phase && m_cmd_valid && m_cmd_ready) begin
              m_cmd_valid <= 1'b0;
              wait_phase  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_owr_temp_sequencer.sv
// Bench for owr_temp_sequencer: one triggered instance and one auto-periodic instance,
// each served by a small 1-wire master model; commands and temperatures checked via queues.
module tb_owr_temp_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, st, rdy, md, pr, stall_wr, pres_v;
  logic        cv [2];
  logic        busy [2];
  logic        tv [2];
  logic        err [2];
  logic [1:0]  cmd [2];
  logic [7:0]  wd [2];
  logic [7:0]  rd [2];
  logic [15:0] temp [2];
  logic [7:0]  lsb_v, msb_v;

  logic [9:0]  pcmd [2];
  bit          pend [2];
  int          ridx [2];
  int          ncmd [2];
  int          tvc [2];
  bit          tv_prev [2];
  int          cyc, n_vec, n_bad, t_convdone, t_rstacc;
  bit          conv_seen;
  logic [9:0]  seq_tab [8];
  logic [9:0]  exp_cmd [$];
  logic [15:0] exp_temp [$];

  owr_temp_sequencer #(.CONV_WAIT(25), .PERIOD(0), .TO_CYCLES(8)) u_dut (
    .i_clk(clk), .i_rst(rst[0]), .i_start(st[0]), .o_busy(busy[0]),
    .m_cmd_valid(cv[0]), .m_cmd_ready(rdy[0]), .m_cmd(cmd[0]), .m_wdata(wd[0]),
    .m_done(md[0]), .m_rdata(rd[0]), .m_presence(pr[0]),
    .o_temp(temp[0]), .o_temp_valid(tv[0]), .o_err(err[0])
  );

  owr_temp_sequencer #(.CONV_WAIT(5), .PERIOD(20), .TO_CYCLES(8)) u_per (
    .i_clk(clk), .i_rst(rst[1]), .i_start(st[1]), .o_busy(busy[1]),
    .m_cmd_valid(cv[1]), .m_cmd_ready(rdy[1]), .m_cmd(cmd[1]), .m_wdata(wd[1]),
    .m_done(md[1]), .m_rdata(rd[1]), .m_presence(pr[1]),
    .o_temp(temp[1]), .o_temp_valid(tv[1]), .o_err(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Master model: decides ready and accepts at the negedge, completes one cycle later.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      md[g] = 1'b0;
      if (rst[g]) begin
        pend[g] = 1'b0;
      end else if (pend[g]) begin
        chk("valid_drop", 32'(cv[g]), 32'd0);
        md[g]   = 1'b1;
        pend[g] = 1'b0;
        if (g == 0 && pcmd[0] == 10'h144) begin
          t_convdone = cyc;
          conv_seen  = 1'b1;
        end
      end else begin
        rdy[g] = !(stall_wr[g] && cmd[g] == 2'b01);
        if (cv[g] && rdy[g]) begin
          pend[g] = 1'b1;
          pcmd[g] = {cmd[g], wd[g]};
          ncmd[g]++;
          pr[g] = pres_v[g];
          if (pcmd[g] == 10'h1BE) ridx[g] = 0;
          if (cmd[g] == 2'b10) begin
            rd[g] = (ridx[g] == 0) ? lsb_v : msb_v;
            ridx[g]++;
          end
          if (g == 0) begin
            if (cmd[0] == 2'b00) t_rstacc = cyc;
            if (exp_cmd.size() == 0) chk("cmd_extra", 32'(pcmd[0]), 32'h3FF);
            else chk("cmd_order", 32'(pcmd[0]), 32'(exp_cmd.pop_front()));
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (tv[g]) begin
        tvc[g]++;
        chk("tv_one_cycle", 32'(tv_prev[g]), 32'd0);
        chk("busy_at_tv", 32'(busy[g]), 32'd0);
        if (g == 1) chk("temp_per", 32'(temp[1]), 32'h0550);
        else if (exp_temp.size() == 0) chk("temp_extra", 32'(temp[0]), 32'hFFFFFFFF);
        else chk("temp", 32'(temp[0]), 32'(exp_temp.pop_front()));
      end
      tv_prev[g] = tv[g];
    end
  end

  task automatic push_seq(input int n);
    for (int i = 0; i < n; i++) exp_cmd.push_back(seq_tab[i]);
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk);
    st[g] = 1'b1;
    @(negedge clk);
    st[g] = 1'b0;
  endtask

  task automatic wait_busy(input int g, input logic lvl, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy[g] == lvl) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("busy_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_rst0(input string p);
    chk({p, "_busy"},  32'(busy[0]), 32'd0);
    chk({p, "_valid"}, 32'(cv[0]),   32'd0);
    chk({p, "_cmd"},   32'(cmd[0]),  32'd0);
    chk({p, "_wdata"}, 32'(wd[0]),   32'd0);
    chk({p, "_temp"},  32'(temp[0]), 32'd0);
    chk({p, "_tv"},    32'(tv[0]),   32'd0);
    chk({p, "_err"},   32'(err[0]),  32'd0);
  endtask

  initial begin
    int t, t_end, c0, nv, n_before, tv_before;
    bit found;
    seq_tab[0] = 10'h000; seq_tab[1] = 10'h1CC; seq_tab[2] = 10'h144; seq_tab[3] = 10'h000;
    seq_tab[4] = 10'h1CC; seq_tab[5] = 10'h1BE; seq_tab[6] = 10'h200; seq_tab[7] = 10'h200;
    rst = 2'b00; st = 2'b00; rdy = 2'b11; md = 2'b00; pr = 2'b11;
    stall_wr = 2'b00; pres_v = 2'b11; lsb_v = 8'h50; msb_v = 8'h05;
    rd[0] = 8'h00; rd[1] = 8'h00;
    #1 rst = 2'b11;
    #1 chk_rst0("reset");
    repeat (3) @(negedge clk);

    // Periodic instance: auto-start timing, i_start while busy ignored.
    rst[1] = 1'b0;
    c0 = cyc;
    wait_busy(1, 1'b1, 100, t);
    chk("per_first_start", 32'(t - c0), 32'd20);
    pulse_start(1);
    wait_busy(1, 1'b0, 200, t_end);
    @(negedge clk);
    chk("per_cmds_1", 32'(ncmd[1]), 32'd8);
    chk("per_tv_1", 32'(tvc[1]), 32'd1);
    wait_busy(1, 1'b1, 100, t);
    chk("per_repeat", 32'(t - t_end), 32'd20);
    wait_busy(1, 1'b0, 200, t_end);
    @(negedge clk);
    chk("per_cmds_2", 32'(ncmd[1]), 32'd16);
    chk("per_err", 32'(err[1]), 32'd0);
    rst[1] = 1'b1;

    // Triggered instance: nothing happens without a start.
    rst[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_no_cmd", 32'(ncmd[0]), 32'd0);
    chk("idle_busy", 32'(busy[0]), 32'd0);

    // Normal measurement.
    push_seq(8);
    exp_temp.push_back(16'h0550);
    pulse_start(0);
    chk("start_busy", 32'(busy[0]), 32'd1);
    wait_busy(0, 1'b0, 200, t);
    @(negedge clk);
    chk("norm_tv_count", 32'(tvc[0]), 32'd1);
    chk("norm_err", 32'(err[0]), 32'd0);
    chk("norm_temp_hold", 32'(temp[0]), 32'h0550);
    chk("norm_cmd_left", 32'(exp_cmd.size()), 32'd0);
    chk("norm_temp_left", 32'(exp_temp.size()), 32'd0);
    chk("conv_gap", 32'(t_rstacc - t_convdone), 32'd26);

    // No presence on RST1.
    pres_v[0] = 1'b0;
    push_seq(1);
    n_before = ncmd[0];
    tv_before = tvc[0];
    pulse_start(0);
    wait_busy(0, 1'b0, 50, t);
    @(negedge clk);
    chk("nopres_err", 32'(err[0]), 32'd1);
    chk("nopres_temp", 32'(temp[0]), 32'h0550);
    repeat (40) @(negedge clk);
    chk("nopres_cmds", 32'(ncmd[0] - n_before), 32'd1);
    chk("nopres_no_tv", 32'(tvc[0] - tv_before), 32'd0);
    chk("nopres_idle", 32'(busy[0]), 32'd0);
    chk("nopres_err_hold", 32'(err[0]), 32'd1);
    pres_v[0] = 1'b1;
    lsb_v = 8'h91; msb_v = 8'h01;
    push_seq(8);
    exp_temp.push_back(16'h0191);
    pulse_start(0);
    chk("err_cleared", 32'(err[0]), 32'd0);
    wait_busy(0, 1'b0, 200, t);
    @(negedge clk);
    chk("seq2_err", 32'(err[0]), 32'd0);
    chk("seq2_cmd_left", 32'(exp_cmd.size()), 32'd0);

    // Ready held low on the first write: fields stable, watchdog aborts after 8 cycles.
    stall_wr[0] = 1'b1;
    push_seq(1);
    pulse_start(0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cv[0] && cmd[0] == 2'b01) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("stall_seen", 32'(found), 32'd1);
    nv = 0;
    repeat (10) begin
      if (cv[0]) begin
        nv++;
        chk("stall_cmd", 32'(cmd[0]), 32'd1);
        chk("stall_wdata", 32'(wd[0]), 32'hCC);
      end
      @(negedge clk);
    end
    chk("wd_valid_cycles", 32'(nv), 32'd8);
    chk("wd_err", 32'(err[0]), 32'd1);
    chk("wd_idle", 32'(busy[0]), 32'd0);
    chk("wd_cmd_left", 32'(exp_cmd.size()), 32'd0);
    stall_wr[0] = 1'b0;

    // Reset asserted mid-WAITC.
    conv_seen = 1'b0;
    push_seq(3);
    pulse_start(0);
    for (int i = 0; i < 60 && !conv_seen; i++) @(negedge clk);
    chk("conv_reached", 32'(conv_seen), 32'd1);
    repeat (5) @(negedge clk);
    chk("in_waitc", 32'(busy[0]), 32'd1);
    #2 rst[0] = 1'b1;
    #1 chk_rst0("async_rst");
    @(negedge clk);
    rst[0] = 1'b0;
    n_before = ncmd[0];
    repeat (60) @(negedge clk);
    chk("post_rst_no_cmd", 32'(ncmd[0] - n_before), 32'd0);
    chk("post_rst_idle", 32'(busy[0]), 32'd0);
    chk("post_rst_cmd_left", 32'(exp_cmd.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
